// File: rtl/sw_debounce_pkg.sv
// Shared constants for the slide-switch debouncer: default geometry and filter depth.
// Simulation overrides the filter depth at instantiation.
package sw_debounce_pkg;

    localparam int unsigned SW_WIDTH         = 8;
    localparam int unsigned SW_STABLE_CYCLES = 16;

    // Counter width able to hold 0..stable_cycles.
    function automatic int unsigned cnt_width(input int unsigned stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter, filtered level and edge pulses.
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = SW_STABLE_CYCLES
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    localparam int unsigned     CNT_W    = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous switch level into the clk domain.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= d;
            sync2 <= sync1;
        end
    end

    // Any matching cycle restarts the count, so only an unbroken mismatch run updates q.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt  <= '0;
            q    <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync2 == q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt  <= '0;
                q    <= sync2;
                rise <= sync2;
                fall <= ~sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// Debounces a bank of board slide switches; per-bit levels and edge pulses plus
// a single any-change strobe for edge-triggered consumers.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int unsigned WIDTH         = SW_WIDTH,
    parameter int unsigned STABLE_CYCLES = SW_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_chg
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_bit (
            .clk    (clk),
            .resetn (resetn),
            .d      (sw[i]),
            .q      (sw_db[i]),
            .rise   (sw_rise[i]),
            .fall   (sw_fall[i])
        );
    end

    // Pure OR of flop outputs: cycle-aligned with the per-bit pulses.
    assign sw_chg = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_sw_debounce.sv
// Directed and random stimulus for sw_debounce against a windowed reference model.
module tb_sw_debounce;

    localparam int unsigned W    = 8;
    localparam int unsigned S    = 4;
    localparam int unsigned HIST = S + 2;

    logic         clk;
    logic         resetn;
    logic [W-1:0] sw;
    logic [W-1:0] sw_db;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         sw_chg;

    int compared;
    int mismatched;

    // Reference: samples of sw taken at each post-reset edge, newest first.
    logic [W-1:0] hist [HIST];
    logic [W-1:0] m_db;
    logic [W-1:0] m_rise;
    logic [W-1:0] m_fall;

    sw_debounce #(
        .WIDTH         (W),
        .STABLE_CYCLES (S)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .sw      (sw),
        .sw_db   (sw_db),
        .sw_rise (sw_rise),
        .sw_fall (sw_fall),
        .sw_chg  (sw_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < HIST; i++) hist[i] = '0;
        m_db   = '0;
        m_rise = '0;
        m_fall = '0;
    endtask

    // A bit flips once its input, seen two edges late, has opposed the output for S edges running.
    task automatic model_edge();
        logic opposed;
        for (int i = HIST - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = sw;
        m_rise  = '0;
        m_fall  = '0;
        for (int b = 0; b < W; b++) begin
            opposed = 1'b1;
            for (int j = 2; j < HIST; j++)
                if (hist[j][b] == m_db[b]) opposed = 1'b0;
            if (opposed) begin
                m_db[b] = ~m_db[b];
                if (m_db[b]) m_rise[b] = 1'b1;
                else         m_fall[b] = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".db"},   sw_db,   m_db);
        check({tag, ".rise"}, sw_rise, m_rise);
        check({tag, ".fall"}, sw_fall, m_fall);
        check({tag, ".chg"},  {7'b0, sw_chg}, {7'b0, |(m_rise | m_fall)});
    endtask

    // Called at a negedge; drives sw, lets one edge happen, checks, returns at next negedge.
    task automatic tick(input logic [W-1:0] v, input string tag);
        sw = v;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic reset_pulse(input int edges);
        resetn = 1'b0;
        model_reset();
        #1;
        check_all("rst_async");
        repeat (edges) @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        resetn     = 1'b0;
        sw         = '1;
        model_reset();

        // Switches already high at reset release appear as a rise after S+2 edges.
        repeat (3) @(posedge clk);
        #1;
        check_all("in_reset");
        @(negedge clk);
        resetn = 1'b1;
        for (int e = 1; e <= 5; e++) tick(8'hFF, "rel_wait");
        check("rel_e5_db", sw_db, 8'h00);
        tick(8'hFF, "rel_e6");
        check("rel_e6_db",   sw_db,   8'hFF);
        check("rel_e6_rise", sw_rise, 8'hFF);
        check("rel_e6_chg",  {7'b0, sw_chg}, 8'h01);
        tick(8'hFF, "rel_e7");
        check("rel_e7_rise", sw_rise, 8'h00);

        // Return to all-low, then a clean step on bit 0.
        repeat (8) tick(8'h00, "clear");
        for (int e = 1; e <= 5; e++) tick(8'h01, "step_wait");
        check("step_e5_db", sw_db, 8'h00);
        tick(8'h01, "step_e6");
        check("step_e6_db",   sw_db,   8'h01);
        check("step_e6_rise", sw_rise, 8'h01);
        repeat (4) tick(8'h01, "step_hold");

        // Bounce on bit 1 never reaches the output.
        repeat (3) tick(8'h03, "bnc_hi1");
        tick(8'h01, "bnc_lo");
        repeat (3) tick(8'h03, "bnc_hi2");
        repeat (8) tick(8'h01, "bnc_settle");
        check("bnc_db", sw_db, 8'h01);

        // Release of bit 0.
        for (int e = 1; e <= 5; e++) tick(8'h00, "rls_wait");
        check("rls_e5_db", sw_db, 8'h01);
        tick(8'h00, "rls_e6");
        check("rls_e6_db",   sw_db,   8'h00);
        check("rls_e6_fall", sw_fall, 8'h01);
        repeat (3) tick(8'h00, "rls_hold");

        // Simultaneous multi-bit step.
        for (int e = 1; e <= 5; e++) tick(8'hA5, "sim_wait");
        tick(8'hA5, "sim_e6");
        check("sim_e6_db",   sw_db,   8'hA5);
        check("sim_e6_rise", sw_rise, 8'hA5);
        check("sim_e6_chg",  {7'b0, sw_chg}, 8'h01);
        tick(8'hA5, "sim_e7");
        check("sim_e7_chg",  {7'b0, sw_chg}, 8'h00);
        repeat (8) tick(8'h00, "sim_clear");

        // Reset mid-count discards progress; latency restarts from release.
        for (int e = 1; e <= 4; e++) tick(8'h04, "mid_pre");
        reset_pulse(2);
        for (int e = 1; e <= 5; e++) tick(8'h04, "mid_wait");
        check("mid_e5_db", sw_db, 8'h00);
        tick(8'h04, "mid_e6");
        check("mid_e6_db",   sw_db,   8'h04);
        check("mid_e6_rise", sw_rise, 8'h04);

        // Random bouncing switches, with occasional resets.
        for (int n = 0; n < 600; n++) begin
            logic [W-1:0] v;
            v = sw;
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 5) == 0) v[b] = ~v[b];
            if ($urandom_range(0, 199) == 0) reset_pulse(1);
            else tick(v, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Input-conditioning stage between the board slide switches (sw[7:0]) and the switch-consuming logic (onoff_switch, led).
- Synchronises each raw switch bit into the clk domain and filters contact bounce.
- Outputs a stable level per bit, plus single-cycle rise/fall pulses and an any-change strobe for edge-triggered consumers.

Parameters:
- WIDTH, 8: number of switch bits handled.
- STABLE_CYCLES, 16: consecutive clk cycles a synchronised bit must differ from its filtered value before the filtered value updates. Must be >= 1.
- CNT_W, $clog2(STABLE_CYCLES+1): per-bit counter width. Derived; not overridden.

Ports:
- clk  input  1  system clock; the only clock.
- resetn  input  1  asynchronous, active-low reset.
- sw  input  WIDTH  raw switch levels; asynchronous to clk.
- sw_db  output  WIDTH  debounced, registered switch levels.
- sw_rise  output  WIDTH  one-cycle pulse per bit when sw_db[i] goes 0->1.
- sw_fall  output  WIDTH  one-cycle pulse per bit when sw_db[i] goes 1->0.
- sw_chg  output  1  one-cycle pulse; OR of sw_rise and sw_fall in the same cycle.

Behaviour:
- Reset (resetn=0, asynchronous, any time): sync1, sync2, sw_db, sw_rise, sw_fall, sw_chg and all counters go to 0 immediately. Reset asserted mid-count discards the count.
- Synchroniser: two flops per bit, sync1 <= sw and sync2 <= sync1. Only sync2 is used downstream.
- Per bit i, at every clk edge:
  - If sync2[i] == sw_db[i]: cnt[i] <= 0. No update.
  - Else if cnt[i] == STABLE_CYCLES-1: sw_db[i] <= sync2[i] and cnt[i] <= 0. Assert sw_rise[i] if sync2[i]=1, otherwise sw_fall[i], for exactly this one cycle.
  - Else: cnt[i] <= cnt[i]+1.
- Per-bit state: IDLE (cnt=0, match) and COUNTING (mismatch). A single matching cycle returns the bit to IDLE, so glitches shorter than STABLE_CYCLES synchronised cycles never reach sw_db.
- Latency: a clean step on sw[i], first sampled at edge 1, updates sw_db[i] at edge STABLE_CYCLES+2. The rise/fall pulse is high during the cycle following that edge.
- STABLE_CYCLES=1: sw_db follows sync2 one edge later, i.e. a plain 3-flop delay.
- sw_rise, sw_fall and sw_chg are registered. They are high for exactly one cycle per sw_db transition and never high together for the same bit.
- Bits are fully independent. Simultaneous transitions on several bits produce simultaneous pulses and a single sw_chg cycle.
- Switches already high when reset is released produce a rise pulse after STABLE_CYCLES+2 cycles. This is intended: consumers see the initial state as an edge.
- Counter never exceeds STABLE_CYCLES-1, so there is no wrap-around.

Decomposition:
- No shared package needed. The default STABLE_CYCLES value goes in the board constants file used by top; simulation overrides it to 4.
- One natural sub-module, sw_debounce_bit: synchroniser, counter, sw_db bit and pulse flops for one bit, with ports clk, resetn, d, q, rise, fall.
- sw_debounce instantiates WIDTH copies with a generate loop and ORs the pulses into sw_chg.

Test Plan (STABLE_CYCLES=4):
- Reset: hold resetn=0 with sw=8'hFF, release, hold sw -> all outputs 0 through edge 5; at edge 6 sw_db=8'hFF, sw_rise=8'hFF and sw_chg=1 for one cycle.
- Clean step: sw[0] 0->1 and held -> sw_db[0]=1 exactly at edge 6 after the change; sw_rise[0] high for one cycle; sw_fall stays 0.
- Bounce: sw[1] pulses high for 3 cycles, low 1 cycle, high 3 cycles, then low -> sw_db[1] stays 0; no pulses at all.
- Release: sw[0] held 1 then set to 0 and held -> sw_db[0] falls 6 edges later; sw_fall[0] single-cycle pulse; sw_rise[0]=0.
- Simultaneous: sw 8'h00 -> 8'hA5 in one cycle -> sw_db=8'hA5 on the same edge; sw_rise=8'hA5 and sw_chg high for exactly one cycle.
- Reset mid-count: sw[2] rises, resetn pulsed low at edge 4 -> sw_db[2]=0 immediately; after release the full 6-edge latency restarts.
